// File: rtl/palette_pkg.sv
// Shared types for the palette RAM arbiter: address/color widths,
// their typedefs and the arbiter FSM state encoding.
package palette_pkg;

    localparam int PAL_AW = 5;
    localparam int PAL_DW = 6;

    typedef logic [PAL_AW-1:0] pal_addr_t;
    typedef logic [PAL_DW-1:0] pal_color_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        DONE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/palette_arbiter.sv
// Palette RAM slot arbiter. Each ce cycle is one access slot on the single
// port palette RAM. Render owns the slot by default; a latched CPU access
// takes the first slot render does not need, or steals one after losing
// MAX_WAIT-1 consecutive ce slots.
//
// Handshake: cpu_req is a level sampled only while cpu_busy=0. The request
// fields are latched on that edge, cpu_busy stays high until the clk after
// the one-clk cpu_ack pulse, and cpu_req is ignored for the whole time
// cpu_busy=1. render_req is sampled only on ce slots. A result appears one
// clk later as a render_valid pulse, with render_stolen marking a lost slot.
module palette_arbiter
    import palette_pkg::*;
#(
    parameter int MAX_WAIT = 8,
    parameter int AW       = PAL_AW,
    parameter int DW       = PAL_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce,
    input  logic          render_req,
    input  logic [AW-1:0] render_idx,
    output logic [DW-1:0] render_color,
    output logic          render_valid,
    output logic          render_stolen,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_busy,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic [AW-1:0] pal_addr,
    output logic [DW-1:0] pal_din,
    output logic          pal_write,
    input  logic [DW-1:0] pal_dout,
    output arb_state_t    dbg_state
);

    // Last losing slot before the CPU is forced in; MAX_WAIT=1 gives 0,
    // so the CPU wins its very first slot.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    arb_state_t    state;
    logic [7:0]    wait_cnt;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_data;
    logic          lat_we;
    logic          grant;

    // CPU owns this slot: a pending access on a ce cycle where render is
    // idle or has already been given its quota of slots.
    assign grant = ce && (state == PEND) &&
                   (!render_req || (wait_cnt == WAIT_LAST));

    assign pal_addr  = grant ? lat_addr : render_idx;
    assign pal_din   = lat_data;
    assign pal_write = grant && lat_we;

    assign cpu_busy  = (state != IDLE);
    assign cpu_ack   = (state == DONE);
    assign dbg_state = state;

    // CPU access FSM: latch request, wait for a slot, complete, then re-arm.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= 8'd0;
            lat_addr  <= '0;
            lat_data  <= '0;
            lat_we    <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        lat_addr <= cpu_addr;
                        lat_data <= cpu_wdata;
                        lat_we   <= cpu_we;
                        wait_cnt <= 8'd0;
                        state    <= PEND;
                    end
                end
                PEND: begin
                    if (grant) begin
                        if (!lat_we) begin
                            cpu_rdata <= pal_dout;
                        end
                        state <= DONE;
                    end else if (ce && (wait_cnt != 8'hFF)) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Render result register: capture the looked-up color, or flag the slot
    // as stolen and keep the previous color.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            render_color  <= '0;
            render_valid  <= 1'b0;
            render_stolen <= 1'b0;
        end else begin
            render_valid  <= ce && render_req;
            render_stolen <= ce && render_req && grant;
            if (ce && render_req && !grant) begin
                render_color <= pal_dout;
            end
        end
    end

endmodule
